// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press, release,
// long-press and auto-repeat events, plus a registered held level.
module button_event_gen #(
    parameter int unsigned LONG_PRESS_TICKS = 50000000,
    parameter int unsigned REPEAT_TICKS     = 10000000
) (
    input  logic clk_i,
    input  logic s_rst_i,
    input  logic btn_state_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int HW = (LONG_PRESS_TICKS > 1) ? $clog2(LONG_PRESS_TICKS) : 1;
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state        <= WAIT_RELEASE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
            held_o       <= 1'b0;
        end else begin
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
            unique case (state)
                // A level already high out of reset must drop before it counts
                WAIT_RELEASE: begin
                    if (!btn_state_i) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (btn_state_i) begin
                        state    <= PRESSED;
                        press_o  <= 1'b1;
                        held_o   <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    if (!btn_state_i) begin
                        state     <= IDLE;
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state        <= HELD;
                        long_press_o <= 1'b1;
                        rep_cnt      <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_state_i) begin
                        state     <= IDLE;
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                    end else if (rep_cnt == REP_LAST) begin
                        repeat_o <= 1'b1;
                        rep_cnt  <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= WAIT_RELEASE;
                    held_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts the debounced, synchronized button level produced by the input debouncers into discrete single-cycle events for the stopwatch game controller. These events are press, release, long-press and auto-repeat. It sits directly after each debouncer instance and feeds the control FSM. The block ensures that no downstream logic ever edge-detects or times a raw button level itself.

## Interface

Parameters:
- LONG_PRESS_TICKS, default 50000000: clock cycles from press event to long-press event; must be ≥ 2.
- REPEAT_TICKS, default 10000000: clock cycles between consecutive repeat events after long-press; must be ≥ 2.

Ports:
- clk_i  input  1  system clock; single clock domain.
- s_rst_i  input  1  reset, synchronous, active-high.
- btn_state_i  input  1  debounced button level, 1 = pressed; already synchronous to clk_i.
- press_o  output  1  one-cycle pulse on accepted press.
- release_o  output  1  one-cycle pulse on release of an accepted press.
- long_press_o  output  1  one-cycle pulse when hold reaches LONG_PRESS_TICKS.
- repeat_o  output  1  one-cycle pulse every REPEAT_TICKS while held past long-press.
- held_o  output  1  level; 1 while an accepted press is in progress.

## Operation

- Outputs:
  - All outputs are registered.
  - Every output is 0 during and after reset until an event occurs.
- FSM states: WAIT_RELEASE (reset state), IDLE, PRESSED, HELD.
- WAIT_RELEASE:
  - Stays here while btn_state_i = 1.
  - Goes to IDLE on the first edge sampling btn_state_i = 0.
  - No events are emitted in this state. A button held through reset produces no press.
- IDLE:
  - On btn_state_i = 1: go to PRESSED, pulse press_o, clear hold counter.
- PRESSED, btn_state_i = 0: go to IDLE, pulse release_o.
- PRESSED, btn_state_i = 1, hold counter = LONG_PRESS_TICKS-1:
  - Go to HELD, pulse long_press_o, clear repeat counter.
- PRESSED, btn_state_i = 1, other counts: increment hold counter.
- HELD, btn_state_i = 0: go to IDLE, pulse release_o.
- HELD, btn_state_i = 1, repeat counter = REPEAT_TICKS-1:
  - Pulse repeat_o.
  - Repeat counter wraps to 0.
- HELD, btn_state_i = 1, other counts: increment repeat counter.
- held_o is 1 exactly when the state is PRESSED or HELD.
- Counter widths:
  - Hold counter: $clog2(LONG_PRESS_TICKS) bits.
  - Repeat counter: $clog2(REPEAT_TICKS) bits.
  - Counters never pass their maximum; they are compared for equality and reset to 0.
- Simultaneous events:
  - Release has priority over long-press and repeat on the same edge.
  - At most one of press_o, release_o, long_press_o, repeat_o is 1 in any cycle.
- Counters hold their value in IDLE and WAIT_RELEASE, and are cleared on entry as listed.

## Timing

- Latency: an event pulse is high for the one cycle following the edge that samples the causing btn_state_i value.
- Press sampled at edge 0:
  - press_o is high after edge 0.
  - held_o rises after edge 0.
- Long-press, with input held continuously: long_press_o is high after edge LONG_PRESS_TICKS.
- Repeats: repeat_o is high after edges LONG_PRESS_TICKS + n·REPEAT_TICKS, n ≥ 1.
- Release sampled at edge k:
  - release_o is high after edge k.
  - held_o falls after edge k.
- Press again directly after release:
  - Input low for exactly one sampled edge, then high: release_o and press_o come out on consecutive cycles.
- Reset mid-operation:
  - s_rst_i sampled high clears all outputs on that edge.
  - Counters reset to 0.
  - State goes to WAIT_RELEASE, so a still-held button needs release and re-press before the next press_o.
- Reset priority: s_rst_i overrides all other inputs.

## Test plan

Use LONG_PRESS_TICKS = 8 and REPEAT_TICKS = 4 for all scenarios.

- Reset with btn_state_i = 1 held 20 cycles, then 0, then 1 -> no events while held after reset; press_o one cycle after the later rising sample; held_o = 1.
- Short click (press sampled at edge 0, held 3 cycles, released at edge 3) -> press_o after edge 0, release_o after edge 3, no long_press_o, held_o high for 3 cycles.
- Hold 20 cycles (press at edge 0, release at edge 20) -> long_press_o after edge 8; repeat_o after edges 12, 16, 20 is suppressed because release wins at 20; release_o after edge 20.
- Release on the long-press boundary (release sampled at edge 8) -> release_o after edge 8, no long_press_o.
- Reset asserted at edge 10 while held, deasserted, button still high -> all outputs 0 after edge 10; no press until btn_state_i is seen 0 and then 1.
- Throughout all scenarios -> at most one pulse output is high per cycle; each pulse lasts exactly 1 cycle.
